// File: rtl/delay_arbiter_pkg.sv
// Shared types and width helpers for the delay_arbiter scheduler.
// Imported by the round-robin picker and the top level.
package delay_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int lat);
        return $clog2(lat + 2);
    endfunction

endpackage

// File: rtl/delay_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above the
// pointer, wrapping from N_REQ-1 back to 0.
module rr_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = tag_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o
);

    logic          found;
    int            j;
    logic [PW-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = PW'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin front end for a shared fixed-latency pipeline; requester
// IDs ride a matching tag shift register to route results back.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_REQ   = 4,
    parameter int LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic                   pipe_vld_in,
    output logic [WIDTH-1:0]       pipe_din,
    input  logic [WIDTH-1:0]       pipe_dout,
    output logic [N_REQ-1:0]       rsp_vld,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic                   flush_done
);

    localparam int TW = tag_w(N_REQ);
    localparam int CW = cnt_w(LATENCY);

    state_e                      state_q, state_d;
    logic [TW-1:0]               ptr_q, ptr_d;
    logic [N_REQ-1:0]            arb_gnt;
    logic [TW-1:0]               win;
    logic                        run_ok;
    logic                        xfer;
    logic                        vld_q;
    logic [WIDTH-1:0]            din_q;
    logic [TW-1:0]               itag_q;
    logic [LATENCY-1:0]          tv_q;
    logic [LATENCY-1:0][TW-1:0]  tt_q;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        rsp_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (TW)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (win)
    );

    // Grant only while RUN will persist, so a falling en or rising flush
    // blocks the transfer in the same cycle.
    assign run_ok  = (state_q == ST_RUN) && en && !flush;
    assign gnt     = run_ok ? arb_gnt : '0;
    assign xfer    = |(req & gnt);
    assign rsp_hit = tv_q[LATENCY-1];

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (en && !flush) state_d = ST_RUN;
            ST_RUN:   if (flush || !en) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (win == TW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (xfer && !rsp_hit)      cnt_d = cnt_q + 1'b1;
        else if (!xfer && rsp_hit) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            din_q  <= '0;
            itag_q <= '0;
            tv_q   <= '0;
            tt_q   <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= xfer;
            if (xfer) begin
                din_q  <= req_data[win*WIDTH +: WIDTH];
                itag_q <= win;
            end
            tv_q[0] <= vld_q;
            tt_q[0] <= itag_q;
            for (int i = 1; i < LATENCY; i++) begin
                tv_q[i] <= tv_q[i-1];
                tt_q[i] <= tt_q[i-1];
            end
            cnt_q <= cnt_d;
        end
    end

    assign pipe_vld_in = vld_q;
    assign pipe_din    = din_q;
    assign busy        = (cnt_q != '0);
    assign rsp_vld     = rsp_hit ? (N_REQ'(1) << tt_q[LATENCY-1]) : '0;
    assign rsp_data    = rsp_hit ? pipe_dout : '0;

    a_cnt_ovf: assert property (@(posedge clk) disable iff (rst)
        !(xfer && !rsp_hit && cnt_q == CW'(LATENCY + 1)));
    a_cnt_unf: assert property (@(posedge clk) disable iff (rst)
        !(rsp_hit && !xfer && cnt_q == '0));

endmodule

// File: doc/delay_arbiter.md
Name: delay_arbiter

Overview:
- Round-robin scheduler that shares one fixed-latency pipeline (the shared delay/pixel-processing stage) among N_REQ requesters.
- Accepts one request per cycle and issues it to the pipeline.
- Carries the requester ID through a tag shift register of the same latency, then routes each returning result back to its owner.
- Enable/flush sequencing lets the top level drain the pipeline cleanly, e.g. at frame boundaries.

Parameters:
- WIDTH, 8, bit width of request/response data
- N_REQ, 4, number of requesters (>=2)
- LATENCY, 3, fixed latency in clocks of the shared pipeline, pipe_din to pipe_dout (>=1)

Ports:
- clk  input  1  posedge clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  level; 1 = arbitration allowed
- flush  input  1  level; request drain to IDLE
- req  input  N_REQ  per-requester request, held until granted
- req_data  input  N_REQ*WIDTH  request data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  combinational one-hot grant; transfer = req[i]&gnt[i]
- pipe_vld_in  output  1  registered issue strobe to the shared pipeline
- pipe_din  output  WIDTH  registered data to the shared pipeline
- pipe_dout  input  WIDTH  shared pipeline output
- rsp_vld  output  N_REQ  one-hot response strobe
- rsp_data  output  WIDTH  response data, valid when any rsp_vld bit is set
- busy  output  1  1 when outstanding != 0
- flush_done  output  1  one-cycle pulse when DRAIN completes

Behaviour:
- Reset values:
  - gnt, pipe_vld_in, pipe_din, rsp_vld, rsp_data, busy, flush_done = 0
  - RR pointer = 0, all tag stages invalid, outstanding = 0, state = IDLE
- FSM:
  - IDLE -> RUN when en=1 and flush=0.
  - RUN -> DRAIN when flush=1 or en=0.
  - DRAIN -> IDLE when outstanding==0; flush_done=1 in the cycle of that transition.
  - flush held high keeps the FSM in IDLE.
- gnt is nonzero only in RUN.
- Winner selection: first i with req[i]=1, scanning from the RR pointer upward with wrap at N_REQ-1 -> 0.
- On a transfer edge, the RR pointer becomes (winner+1) mod N_REQ. With no transfer, the pointer holds.
- Issue stage, registered:
  - On a transfer edge: pipe_vld_in<=1, pipe_din<=req_data[winner], issue tag<=winner.
  - Otherwise pipe_vld_in<=0 and pipe_din holds.
  - At most one issue per cycle.
- Tag pipeline: LATENCY stages of {valid, tag}, shifted every cycle with no stall. Stage 0 is loaded from {pipe_vld_in, issue tag}.
- Response:
  - When the last tag stage is valid: rsp_vld is one-hot at the tag index and rsp_data=pipe_dout, both combinational from the last stage.
  - Otherwise rsp_vld=0 and rsp_data=0.
- Latency: the response arrives LATENCY+1 cycles after the transfer edge. Throughput is 1 per cycle.
- outstanding counter:
  - Width $clog2(LATENCY+2).
  - +1 on issue, -1 on response, unchanged when both occur in the same cycle.
  - Never exceeds LATENCY+1; an overflow/underflow assertion is required in simulation.
- Mid-transfer disable: if en falls or flush rises in the same cycle as req&gnt, that transfer is still not granted. gnt is already 0 because the FSM leaves RUN on that edge; evaluation is based on the current state.
- Responses continue to be delivered in DRAIN and IDLE.
- rst mid-operation clears all in-flight tags. No rsp_vld follows reset, regardless of pipe_dout.
- A requester with req=0 is never granted. A single requester holding req continuously is granted every cycle.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/RUN/DRAIN)
  - tag width function $clog2(N_REQ)
  - outstanding-counter width helper
- Sub-module rr_arbiter (parameter N_REQ):
  - Inputs: req, pointer.
  - Outputs: one-hot gnt, binary winner index.
  - Purely combinational.
- The top level holds the FSM, pointer register, issue register, tag shift register and counter.

Test Plan:
- Single requester: en=1, req=4'b0010, req_data[1]=8'hA5, held 1 cycle.
  -> gnt=4'b0010 that cycle; pipe_vld_in=1 and pipe_din=8'hA5 next cycle; with model pipe_dout=din+1 delayed 3: rsp_vld=4'b0010, rsp_data=8'hA6 exactly 4 cycles after the transfer.
- Fairness: req=4'b1111 held for 8 cycles, pointer=0.
  -> gnt sequence 0001,0010,0100,1000,0001,...; each requester receives exactly 2 responses, in grant order.
- Wrap/skip: pointer=3, req=4'b0101.
  -> gnt=4'b0001, then 4'b0100, then 4'b0001.
- Flush with 4 in flight: stream issued back-to-back, then flush=1.
  -> gnt=0 immediately; all 4 responses still delivered; busy falls; flush_done pulses once in the same cycle the FSM enters IDLE; no grants while flush=1.
- Reset mid-flight: 3 issues, then rst asserted asynchronously mid-cycle.
  -> all outputs 0 immediately; after release, rsp_vld stays 0 even with pipe_dout nonzero; outstanding=0.
- Disable edge: en falls in the same cycle as req=4'b0001.
  -> no transfer, pipe_vld_in stays 0, state goes DRAIN -> IDLE with flush_done pulse.
